// File: rtl/branch_pkg.sv
// Shared definitions for the branch history table: RISC-V branch funct3
// encodings and the 2-bit saturating counter state.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch/EX-side signal bundle of the branch history table.
interface branch_predictor_bht_if;

    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic        i_ex_valid;
    logic        i_ex_is_branch;
    logic [31:0] i_ex_pc;
    logic [2:0]  i_ex_funct3;
    logic        i_ex_pred_taken;
    logic        i_br_less;
    logic        i_br_equal;
    logic        o_br_taken;
    logic        o_mispredict;
    logic [31:0] o_branch_cnt;
    logic [31:0] o_mispred_cnt;

    modport master (
        output i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_funct3,
               i_ex_pred_taken, i_br_less, i_br_equal,
        input  o_pred_taken, o_br_taken, o_mispredict, o_branch_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_funct3,
               i_ex_pred_taken, i_br_less, i_br_equal,
        output o_pred_taken, o_br_taken, o_mispredict, o_branch_cnt, o_mispred_cnt
    );

endinterface

// File: rtl/branch_predictor_bht_sat_counter_2b.sv
// Next-state logic of one 2-bit saturating taken/not-taken counter.
module sat_counter_2b
    import branch_pkg::*;
(
    input  bht_state_t i_state,
    input  logic       i_taken,
    output bht_state_t o_next
);

    always_comb begin
        o_next = i_state;
        unique case (i_state)
            SNT: o_next = i_taken ? WNT : SNT;
            WNT: o_next = i_taken ? WT  : SNT;
            WT:  o_next = i_taken ? ST  : WNT;
            ST:  o_next = i_taken ? ST  : WT;
            default: o_next = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table: resolves EX branch direction, trains 2-bit counters,
// predicts for fetch, flags mispredictions and keeps statistics.
module branch_predictor_bht
    import branch_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    branch_predictor_bht_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    bht_state_t        r_table [BHT_ENTRIES];
    logic [31:0]       r_branch_cnt;
    logic [31:0]       r_mispred_cnt;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    bht_state_t        w_if_state;
    bht_state_t        w_ex_state;
    bht_state_t        w_ex_next;
    logic              w_res;
    logic              w_taken;
    logic              w_legal;
    logic              w_update;
    logic              w_mispredict;
    logic              w_unused_pc;

    assign w_if_idx   = bus.i_if_pc[IDX_W+1:2];
    assign w_ex_idx   = bus.i_ex_pc[IDX_W+1:2];
    assign w_if_state = r_table[w_if_idx];
    assign w_ex_state = r_table[w_ex_idx];

    assign w_unused_pc = ^{bus.i_if_pc[31:IDX_W+2], bus.i_if_pc[1:0],
                           bus.i_ex_pc[31:IDX_W+2], bus.i_ex_pc[1:0]};

    // Illegal funct3 encodings resolve not-taken and never train the table.
    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        unique case (bus.i_ex_funct3)
            F3_BEQ:  w_taken = bus.i_br_equal;
            F3_BNE:  w_taken = ~bus.i_br_equal;
            F3_BLT:  w_taken = bus.i_br_less;
            F3_BGE:  w_taken = ~bus.i_br_less;
            F3_BLTU: w_taken = bus.i_br_less;
            F3_BGEU: w_taken = ~bus.i_br_less;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_res        = bus.i_ex_valid & bus.i_ex_is_branch;
    assign w_update     = w_res & w_legal;
    assign w_mispredict = w_update & (w_taken != bus.i_ex_pred_taken);

    sat_counter_2b u_sat (
        .i_state (w_ex_state),
        .i_taken (w_taken),
        .o_next  (w_ex_next)
    );

    // Fetch reads the registered table directly, so a same-cycle update is
    // only visible from the following cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                r_table[i[IDX_W-1:0]] <= WNT;
            end
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_update) begin
            r_table[w_ex_idx] <= w_ex_next;
            r_branch_cnt      <= r_branch_cnt + 32'd1;
            if (w_mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign bus.o_pred_taken  = w_if_state[1];
    assign bus.o_br_taken    = w_res & w_taken;
    assign bus.o_mispredict  = w_mispredict;
    assign bus.o_branch_cnt  = r_branch_cnt;
    assign bus.o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed, table-driven bench for branch_predictor_bht.
module tb_branch_predictor_bht;

    logic i_clk;
    logic i_reset;
    int   n_cmp;
    int   n_fail;
    logic [31:0] exp_b;
    logic [31:0] exp_m;

    branch_predictor_bht_if bus ();

    branch_predictor_bht #(.BHT_ENTRIES(64)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       v;
        logic       b;
        logic [2:0] f3;
        logic       lt;
        logic       eq;
        logic       pred;
        logic       exp_tk;
        logic       exp_mis;
        logic       exp_cnt;
    } vec_t;

    vec_t vecs [34];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic b, input logic [31:0] pc,
                            input logic [2:0] f3, input logic lt, input logic eq,
                            input logic pred);
        bus.i_ex_valid      = v;
        bus.i_ex_is_branch  = b;
        bus.i_ex_pc         = pc;
        bus.i_ex_funct3     = f3;
        bus.i_br_less       = lt;
        bus.i_br_equal      = eq;
        bus.i_ex_pred_taken = pred;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_counts(input string name);
        check({name, "_bcnt"}, bus.o_branch_cnt, exp_b);
        check({name, "_mcnt"}, bus.o_mispred_cnt, exp_m);
    endtask

    task automatic pred_at(input string name, input logic [31:0] pc, input logic exp);
        bus.i_if_pc = pc;
        #1;
        check(name, {31'b0, bus.o_pred_taken}, {31'b0, exp});
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        exp_b = '0;
        exp_m = '0;

        // {valid, is_branch, funct3, less, equal, pred, exp_taken, exp_mispredict, counted}
        vecs[0]  = '{1, 1, 3'b000, 0, 0, 0, 0, 0, 1};
        vecs[1]  = '{1, 1, 3'b000, 0, 1, 0, 1, 1, 1};
        vecs[2]  = '{1, 1, 3'b000, 1, 0, 0, 0, 0, 1};
        vecs[3]  = '{1, 1, 3'b000, 1, 1, 0, 1, 1, 1};
        vecs[4]  = '{1, 1, 3'b001, 0, 0, 0, 1, 1, 1};
        vecs[5]  = '{1, 1, 3'b001, 0, 1, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 3'b001, 1, 0, 0, 1, 1, 1};
        vecs[7]  = '{1, 1, 3'b001, 1, 1, 0, 0, 0, 1};
        vecs[8]  = '{1, 1, 3'b010, 0, 0, 1, 0, 0, 0};
        vecs[9]  = '{1, 1, 3'b010, 0, 1, 1, 0, 0, 0};
        vecs[10] = '{1, 1, 3'b010, 1, 0, 1, 0, 0, 0};
        vecs[11] = '{1, 1, 3'b010, 1, 1, 1, 0, 0, 0};
        vecs[12] = '{1, 1, 3'b011, 0, 0, 1, 0, 0, 0};
        vecs[13] = '{1, 1, 3'b011, 0, 1, 1, 0, 0, 0};
        vecs[14] = '{1, 1, 3'b011, 1, 0, 1, 0, 0, 0};
        vecs[15] = '{1, 1, 3'b011, 1, 1, 1, 0, 0, 0};
        vecs[16] = '{1, 1, 3'b100, 0, 0, 0, 0, 0, 1};
        vecs[17] = '{1, 1, 3'b100, 0, 1, 0, 0, 0, 1};
        vecs[18] = '{1, 1, 3'b100, 1, 0, 0, 1, 1, 1};
        vecs[19] = '{1, 1, 3'b100, 1, 1, 0, 1, 1, 1};
        vecs[20] = '{1, 1, 3'b101, 0, 0, 0, 1, 1, 1};
        vecs[21] = '{1, 1, 3'b101, 0, 1, 0, 1, 1, 1};
        vecs[22] = '{1, 1, 3'b101, 1, 0, 0, 0, 0, 1};
        vecs[23] = '{1, 1, 3'b101, 1, 1, 0, 0, 0, 1};
        vecs[24] = '{1, 1, 3'b110, 0, 0, 0, 0, 0, 1};
        vecs[25] = '{1, 1, 3'b110, 0, 1, 0, 0, 0, 1};
        vecs[26] = '{1, 1, 3'b110, 1, 0, 0, 1, 1, 1};
        vecs[27] = '{1, 1, 3'b110, 1, 1, 0, 1, 1, 1};
        vecs[28] = '{1, 1, 3'b111, 0, 0, 0, 1, 1, 1};
        vecs[29] = '{1, 1, 3'b111, 0, 1, 0, 1, 1, 1};
        vecs[30] = '{1, 1, 3'b111, 1, 0, 0, 0, 0, 1};
        vecs[31] = '{1, 1, 3'b111, 1, 1, 0, 0, 0, 1};
        vecs[32] = '{0, 1, 3'b000, 0, 1, 0, 0, 0, 0};
        vecs[33] = '{1, 0, 3'b001, 0, 0, 1, 0, 0, 0};

        // Reset
        i_reset = 1'b0;
        bus.i_if_pc = 32'h0;
        idle_ex();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        pred_at("reset_pred_0x40", 32'h40, 1'b0);
        check_counts("reset");
        i_reset = 1'b1;
        @(negedge i_clk);
        pred_at("post_reset_pred_0x14", 32'h14, 1'b0);
        check_counts("post_reset");

        // Training: two taken BEQ at 0x40, each mispredicted
        drive_ex(1, 1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0);
        #1;
        check("train_br_taken", {31'b0, bus.o_br_taken}, 32'd1);
        check("train_mispredict", {31'b0, bus.o_mispredict}, 32'd1);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        idle_ex();
        exp_b += 2; exp_m += 2;
        pred_at("train_pred_0x40", 32'h40, 1'b1);
        check_counts("train");

        // Aliasing 0x140 -> same index; ST -> WT -> WNT -> SNT -> SNT
        drive_ex(1, 1, 32'h140, 3'b101, 1'b1, 1'b0, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        pred_at("alias_after1_pred", 32'h40, 1'b1);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        pred_at("alias_after3_pred", 32'h40, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        pred_at("alias_after4_pred", 32'h40, 1'b0);
        exp_b += 4; exp_m += 4;
        // SNT + taken -> WNT (still 0), + taken -> WT (1)
        drive_ex(1, 1, 32'h140, 3'b000, 1'b0, 1'b1, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        pred_at("sat_low_step1_pred", 32'h40, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        idle_ex();
        pred_at("sat_low_step2_pred", 32'h40, 1'b1);
        exp_b += 2;
        check_counts("alias");

        // Full decode sweep at pc 0x50
        for (int i = 0; i < 34; i++) begin
            @(negedge i_clk);
            drive_ex(vecs[i].v, vecs[i].b, 32'h50, vecs[i].f3, vecs[i].lt, vecs[i].eq, vecs[i].pred);
            #1;
            check($sformatf("dec%0d_taken", i), {31'b0, bus.o_br_taken}, {31'b0, vecs[i].exp_tk});
            check($sformatf("dec%0d_mis", i), {31'b0, bus.o_mispredict}, {31'b0, vecs[i].exp_mis});
            if (vecs[i].exp_cnt) exp_b += 1;
            if (vecs[i].exp_mis) exp_m += 1;
        end
        @(negedge i_clk);
        idle_ex();
        check_counts("decode");

        // Illegal funct3 alone: no counter change
        drive_ex(1, 1, 32'h50, 3'b011, 1'b1, 1'b1, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        idle_ex();
        check_counts("illegal");

        // Read/write collision at index 5
        bus.i_if_pc = 32'h14;
        drive_ex(1, 1, 32'h14, 3'b000, 1'b0, 1'b1, 1'b0);
        #1;
        check("collide_same_cycle", {31'b0, bus.o_pred_taken}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        idle_ex();
        pred_at("collide_next_cycle", 32'h14, 1'b1);
        exp_b += 1; exp_m += 1;
        check_counts("collide");

        // Async reset mid-resolve
        drive_ex(1, 1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_pred_0x40", {31'b0, bus.o_pred_taken}, 32'd0);
        exp_b = '0; exp_m = '0;
        check_counts("async");
        pred_at("async_pred_0x14", 32'h14, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        idle_ex();
        check_counts("async_held");
        // Entry back at WNT: one taken makes it predict taken
        drive_ex(1, 1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        idle_ex();
        pred_at("async_reinit_wnt", 32'h40, 1'b1);
        exp_b += 1;
        check_counts("async_after");

        // Statistics wrap
        force dut.r_branch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_branch_cnt;
        @(negedge i_clk);
        drive_ex(1, 1, 32'h80, 3'b001, 1'b0, 1'b1, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        idle_ex();
        exp_b = '0; exp_m += 1;
        check_counts("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
